// File: rtl/jpeg_unpack_idct_pkg.sv
// Shared types for the packed-row unpack + inverse Haar path: lane geometry,
// FSM states, the widened coefficient type and the u8 clamp helpers.
package jpeg_unpack_idct_pkg;

    localparam int FIELD_W  = 8;
    localparam int N_FIELDS = 6;
    localparam int LANE_W   = FIELD_W * N_FIELDS;
    localparam int N_LANES  = 8;
    localparam int COEF_W   = 11;

    typedef enum logic [2:0] {IDLE, S1, S2, S3, OUT} state_t;

    typedef logic signed [COEF_W-1:0] coef_t;

    function automatic logic [FIELD_W-1:0] get_field(input logic [LANE_W-1:0] w,
                                                     input logic [2:0] f);
        logic [5:0] lsb;
        lsb = {f, 3'b000};
        return w[lsb +: FIELD_W];
    endfunction

    function automatic coef_t sext8(input logic [FIELD_W-1:0] b);
        return {{(COEF_W-FIELD_W){b[FIELD_W-1]}}, b};
    endfunction

    function automatic logic is_clamped(input coef_t v);
        return v[COEF_W-1] || (v > coef_t'(255));
    endfunction

    function automatic logic [7:0] clamp_u8(input coef_t v);
        if (v[COEF_W-1])
            return 8'd0;
        else if (v > coef_t'(255))
            return 8'd255;
        else
            return v[7:0];
    endfunction

endpackage

// File: rtl/haar_inv_bfly.sv
// Inverse Haar butterfly: sum = a + b, dif = a - b.
// Latency 0 (combinational); no flow control of its own.
// Width must already cover growth; the caller guarantees no overflow.
module haar_inv_bfly #(
    parameter int W = 11
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic signed [W-1:0] dif
);

    assign sum = a + b;
    assign dif = a - b;

endmodule

// File: rtl/jpeg_unpack_idct.sv
// Unpacks eight lane words, runs a 3-stage inverse Haar and emits 8 clamped pixels.
// Latency: accept at edge T, out_valid at T+3; single block in flight.
// Backpressure: in_ready only in IDLE; result held in OUT until out_ready.
module jpeg_unpack_idct
    import jpeg_unpack_idct_pkg::*;
#(
    parameter int COEF_FIELD = 5,
    parameter bit CHECK_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [47:0] y11,
    input  logic [47:0] y21,
    input  logic [47:0] y31,
    input  logic [47:0] y41,
    input  logic [47:0] y51,
    input  logic [47:0] y61,
    input  logic [47:0] y71,
    input  logic [47:0] y81,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [63:0] pix_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        mismatch,
    output logic        sat_flag
);

    state_t             state, state_nxt;
    logic [LANE_W-1:0]  lanes [N_LANES];
    coef_t              coef  [N_LANES];
    logic [7:0]         raw   [N_LANES];
    coef_t              sr    [4];
    coef_t              lhs [4], rhs [4], sum [4], dif [4];
    coef_t              pv    [N_LANES];
    logic [63:0]        pix_nxt;
    logic               sat_nxt, mis_nxt;

    assign lanes[0] = y11;
    assign lanes[1] = y21;
    assign lanes[2] = y31;
    assign lanes[3] = y41;
    assign lanes[4] = y51;
    assign lanes[5] = y61;
    assign lanes[6] = y71;
    assign lanes[7] = y81;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = S1;
            S1:      state_nxt = S2;
            S2:      state_nxt = S3;
            S3:      state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == OUT);
    end

    // The four butterflies are shared by all stages; the state picks operands.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lhs[k] = sr[k];
            rhs[k] = '0;
        end
        case (state)
            S1: begin
                lhs[0] = coef[0];
                rhs[0] = coef[1];
            end
            S2: begin
                rhs[0] = coef[2];
                rhs[1] = coef[3];
            end
            S3: begin
                for (int k = 0; k < 4; k++)
                    rhs[k] = coef[4+k];
            end
            default: ;
        endcase
    end

    for (genvar k = 0; k < 4; k++) begin : g_bfly
        haar_inv_bfly #(.W(COEF_W)) u_bfly (
            .a   (lhs[k]),
            .b   (rhs[k]),
            .sum (sum[k]),
            .dif (dif[k])
        );
    end

    always_comb begin
        pix_nxt = '0;
        sat_nxt = 1'b0;
        mis_nxt = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pv[2*k]   = sum[k];
            pv[2*k+1] = dif[k];
        end
        for (int j = 0; j < N_LANES; j++) begin
            pix_nxt[j*8 +: 8] = clamp_u8(pv[j]);
            sat_nxt           = sat_nxt | is_clamped(pv[j]);
            mis_nxt           = mis_nxt | (clamp_u8(pv[j]) != raw[j]);
        end
        mis_nxt = mis_nxt & CHECK_EN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_LANES; i++) begin
                coef[i] <= '0;
                raw[i]  <= '0;
            end
            for (int k = 0; k < 4; k++)
                sr[k] <= '0;
            pix_out  <= '0;
            sat_flag <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < N_LANES; i++) begin
                            coef[i] <= sext8(get_field(lanes[i], 3'(COEF_FIELD)));
                            raw[i]  <= lanes[i][7:0];
                        end
                    end
                end
                S1: begin
                    sr[0] <= sum[0];
                    sr[1] <= dif[0];
                end
                S2: begin
                    sr[0] <= sum[0];
                    sr[1] <= dif[0];
                    sr[2] <= sum[1];
                    sr[3] <= dif[1];
                end
                S3: begin
                    pix_out  <= pix_nxt;
                    sat_flag <= sat_nxt;
                    mismatch <= mis_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jpeg_unpack_idct.sv
// Bench for jpeg_unpack_idct: directed and random blocks against an
// inverse-Haar synthesis-formula model, plus backpressure and reset cases.
module tb_jpeg_unpack_idct;

    localparam int CF = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] lw [8];
    logic        in_valid, in_ready, out_valid, out_ready, mismatch, sat_flag;
    logic [63:0] pix_out;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          tc [8];
    logic [7:0]  tr [8];

    always #5 clk = ~clk;

    jpeg_unpack_idct #(.COEF_FIELD(CF), .CHECK_EN(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .y11       (lw[0]),
        .y21       (lw[1]),
        .y31       (lw[2]),
        .y41       (lw[3]),
        .y51       (lw[4]),
        .y61       (lw[5]),
        .y71       (lw[6]),
        .y81       (lw[7]),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pix_out   (pix_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mismatch  (mismatch),
        .sat_flag  (sat_flag)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pixel j = c0 +/- c1 +/- c[2 + j/4] +/- c[4 + j/2], signs from the bits of j.
    task automatic compute_exp(output logic [63:0] px, output logic sat, output logic mis);
        int p;
        px = '0;
        sat = 1'b0;
        mis = 1'b0;
        for (int j = 0; j < 8; j++) begin
            p = tc[0];
            p += (j < 4) ? tc[1] : -tc[1];
            p += ((j / 2) % 2 == 0) ? tc[2 + j/4] : -tc[2 + j/4];
            p += (j % 2 == 0) ? tc[4 + j/2] : -tc[4 + j/2];
            if (p < 0) begin
                p = 0;
                sat = 1'b1;
            end else if (p > 255) begin
                p = 255;
                sat = 1'b1;
            end
            px[j*8 +: 8] = 8'(p);
            if (8'(p) !== tr[j]) mis = 1'b1;
        end
    endtask

    task automatic load_lanes;
        logic [47:0] w;
        for (int i = 0; i < 8; i++) begin
            w = 48'({$urandom, $urandom});
            w[CF*8 +: 8] = 8'(tc[i]);
            w[7:0] = tr[i];
            lw[i] = w;
        end
    endtask

    task automatic set_coefs(input int c0, input int c1, input int c2, input int c3,
                             input int c4, input int c5, input int c6, input int c7);
        tc[0] = c0; tc[1] = c1; tc[2] = c2; tc[3] = c3;
        tc[4] = c4; tc[5] = c5; tc[6] = c6; tc[7] = c7;
    endtask

    task automatic raw_matches;
        logic [63:0] px;
        logic s, m;
        compute_exp(px, s, m);
        for (int j = 0; j < 8; j++) tr[j] = px[j*8 +: 8];
    endtask

    task automatic rand_block;
        logic [63:0] px;
        logic s, m;
        for (int i = 0; i < 8; i++) begin
            tc[i] = int'($urandom_range(0, 255)) - 128;
            tr[i] = 8'($urandom);
        end
        if ($urandom_range(0, 1) == 1) raw_matches();
    endtask

    task automatic run_block(input string tag);
        logic [63:0] ep;
        logic es, em, early;
        compute_exp(ep, es, em);
        load_lanes();
        in_valid = 1'b1;
        out_ready = 1'b1;
        check({tag, " in_ready"}, in_ready, 1);
        tick;
        in_valid = 1'b0;
        early = out_valid;
        tick;
        early |= out_valid;
        tick;
        early |= out_valid;
        tick;
        check({tag, " latency"}, {early, out_valid}, 2'b01);
        check({tag, " pix"}, pix_out, ep);
        check({tag, " sat"}, sat_flag, es);
        check({tag, " mismatch"}, mismatch, em);
        tick;
        check({tag, " release"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin : main
        logic [63:0] ep, eb, held;
        logic es, em, ok, seen;
        logic [63:0] q [$];
        int acc [$];
        int got, sent;
        bit took;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) lw[i] = '0;
        tick;
        tick;
        check("reset outputs", {out_valid, mismatch, sat_flag}, 3'b000);
        check("reset pix", pix_out, 64'h0);
        rst = 1'b0;
        tick;
        check("in_ready after reset", in_ready, 1);

        // DC only
        set_coefs(100, 0, 0, 0, 0, 0, 0, 0);
        raw_matches();
        run_block("dc");
        check("dc literal", pix_out, 64'h6464646464646464);

        // Level-3 detail, raw agreeing then one lane disagreeing
        set_coefs(100, 10, 0, 0, 0, 0, 0, 0);
        raw_matches();
        run_block("l3 match");
        check("l3 literal", pix_out, 64'h5A5A5A5A6E6E6E6E);
        tr[5] = 8'd91;
        run_block("l3 lane5 off");

        // Saturation high and low
        set_coefs(127, 127, 127, 0, 127, 0, 0, 0);
        raw_matches();
        run_block("sat high");
        check("sat high p0p1", pix_out[15:0], 16'hFEFF);
        set_coefs(-128, 0, 0, 0, 0, 0, 0, 0);
        raw_matches();
        run_block("sat low");

        for (int n = 0; n < 12; n++) begin
            rand_block();
            run_block($sformatf("rand%0d", n));
        end

        // Backpressure: block A held while block B waits on the input
        rand_block();
        compute_exp(ep, es, em);
        load_lanes();
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        tick;
        check("bp out_valid", out_valid, 1);
        check("bp pix A", pix_out, ep);
        held = pix_out;
        rand_block();
        compute_exp(eb, es, em);
        load_lanes();
        in_valid = 1'b1;
        ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick;
            if (pix_out !== held || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
        end
        check("bp hold 10 cycles", ok, 1);
        out_ready = 1'b1;
        tick;
        check("bp handshake", {out_valid, in_ready}, 2'b01);
        tick;
        in_valid = 1'b0;
        check("bp B accepted", in_ready, 0);
        tick;
        tick;
        check("bp B not yet", out_valid, 0);
        tick;
        check("bp B valid", out_valid, 1);
        check("bp B pix", pix_out, eb);
        check("bp B sat/mis", {sat_flag, mismatch}, {es, em});
        tick;

        // Asynchronous reset while the block sits in S2
        check("pre-reset pix nonzero", (pix_out != 64'h0), 1);
        rand_block();
        load_lanes();
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        #2;
        rst = 1'b1;
        #1;
        check("async rst outputs", {out_valid, sat_flag, mismatch}, 3'b000);
        check("async rst pix", pix_out, 64'h0);
        tick;
        #3;
        rst = 1'b0;
        tick;
        check("post-rst in_ready", in_ready, 1);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick;
            seen |= out_valid;
        end
        check("no stale output", seen, 0);

        // Back-to-back: input and output always offered
        out_ready = 1'b1;
        rand_block();
        load_lanes();
        in_valid = 1'b1;
        sent = 0;
        got = 0;
        for (int cyc = 0; cyc < 45; cyc++) begin
            took = 1'b0;
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("b2b unexpected output", 1, 0);
                end else begin
                    check($sformatf("b2b pix %0d", got), pix_out, q.pop_front());
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                compute_exp(ep, es, em);
                q.push_back(ep);
                acc.push_back(cyc);
                sent++;
                took = 1'b1;
            end
            tick;
            if (took) begin
                if (sent < 6) begin
                    rand_block();
                    load_lanes();
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("b2b blocks out", got, 6);
        for (int i = 1; i < acc.size(); i++)
            check($sformatf("b2b spacing %0d", i), acc[i] - acc[i-1], 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
